// File: rtl/tlb_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tlb_ctrl_seq
//   Sequential TLB control for one MMU path (instruction or data). It
//   classifies each lookup as translated or bare, checks the virtual address
//   is canonical for Sv39/Sv48/Sv57, and checks the hit entry's permissions.
//   Around that check it sequences:
//     - misses to the page table walker (request, wait, fill or fault),
//     - hardware A/D-bit updates through a request/acknowledge handshake,
//     - sfence.vma flushes, invalidating one TLB entry per cycle.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   SATP_MODE             0 = bare, 8/9/10 = Sv39/Sv48/Sv57
//   VAdr                  virtual address of the access
//   PrivilegeModeW        current privilege (0=U, 1=S, 3=M)
//   STATUS_MXR/SUM/MPRV   mstatus bits
//   STATUS_MPP            mstatus previous privilege
//   ReadAccess/WriteAccess access request
//   DisableTranslation    force bare addressing
//   CAMHit                TLB lookup hit
//   PTEAccessBits         {D,A,G,U,X,W,R,V} of the hit entry
//   Misaligned            misaligned superpage
//   TLBFlush              sfence.vma pulse
//   WalkAck/WalkDone/WalkFault  walker handshake and result
//   DAAck                 A/D update written back
//   Translate             translation active (combinational)
//   TLBHit                usable hit this cycle
//   TLBPageFault          page fault
//   TLBStall              hold the pipeline
//   WalkReq/WalkAbort     walker request / cancel
//   TLBWrite              write walked PTE into the TLB
//   DAReq                 request hardware A/D update
//   FlushValid/FlushIdx   invalidate TLB entry FlushIdx
// -----------------------------------------------------------------------------
module tlb_ctrl_seq #(
    parameter int XLEN    = 64,
    parameter int ITLB    = 0,
    parameter int ENTRIES = 16,
    parameter int SVADU   = 1,
    parameter int MAXMODE = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  SATP_MODE,
    input  logic [XLEN-1:0]             VAdr,
    input  logic [1:0]                  PrivilegeModeW,
    input  logic                        STATUS_MXR,
    input  logic                        STATUS_SUM,
    input  logic                        STATUS_MPRV,
    input  logic [1:0]                  STATUS_MPP,
    input  logic                        ReadAccess,
    input  logic                        WriteAccess,
    input  logic                        DisableTranslation,
    input  logic                        CAMHit,
    input  logic [7:0]                  PTEAccessBits,
    input  logic                        Misaligned,
    input  logic                        TLBFlush,
    input  logic                        WalkAck,
    input  logic                        WalkDone,
    input  logic                        WalkFault,
    input  logic                        DAAck,
    output logic                        Translate,
    output logic                        TLBHit,
    output logic                        TLBPageFault,
    output logic                        TLBStall,
    output logic                        WalkReq,
    output logic                        WalkAbort,
    output logic                        TLBWrite,
    output logic                        DAReq,
    output logic                        FlushValid,
    output logic [$clog2(ENTRIES)-1:0]  FlushIdx
);

    localparam int                  IDXW     = $clog2(ENTRIES);
    localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(ENTRIES - 1);
    localparam logic                IS_ITLB  = (ITLB != 0);
    localparam logic                HW_AD    = (SVADU != 0);
    localparam logic [3:0]          MAX_MODE = 4'(MAXMODE);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_FILL, S_FAULT, S_ADU, S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   flush_idx_q, flush_idx_d;

    // ---------------- translation enable ----------------
    // Instruction fetches ignore MPRV; data accesses use MPP when MPRV is set.
    logic [1:0] eff_mode;
    assign eff_mode  = (!IS_ITLB && STATUS_MPRV) ? STATUS_MPP : PrivilegeModeW;
    assign Translate = (SATP_MODE != 4'd0) & (eff_mode != 2'b11) & ~DisableTranslation;

    // ---------------- canonical address check ----------------
    logic upper_bits_unequal;
    generate
        if (XLEN >= 57) begin : g_upper
            logic ok39, ok48, ok57;
            assign ok39 = (&VAdr[XLEN-1:38]) | ~(|VAdr[XLEN-1:38]);
            assign ok48 = (&VAdr[XLEN-1:47]) | ~(|VAdr[XLEN-1:47]);
            assign ok57 = (&VAdr[XLEN-1:56]) | ~(|VAdr[XLEN-1:56]);
            always_comb begin
                upper_bits_unequal = 1'b1;   // unsupported modes always fault
                if (SATP_MODE <= MAX_MODE) begin
                    case (SATP_MODE)
                        4'd8:    upper_bits_unequal = ~ok39;
                        4'd9:    upper_bits_unequal = ~ok48;
                        4'd10:   upper_bits_unequal = ~ok57;
                        default: upper_bits_unequal = 1'b1;
                    endcase
                end
            end
        end else begin : g_no_upper
            // Sv32 has no upper address bits to check.
            logic unused_vadr;
            assign unused_vadr        = &{1'b0, VAdr};
            assign upper_bits_unequal = 1'b0;
        end
    endgenerate

    // ---------------- permission check ----------------
    logic pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic unused_pte_g;
    assign {pte_d, pte_a, unused_pte_g, pte_u, pte_x, pte_w, pte_r, pte_v} = PTEAccessBits;

    logic priv_fault, access_fault, need_da, perm_fault;
    assign priv_fault = ((eff_mode == 2'b00) & ~pte_u)
                      | ((eff_mode == 2'b01) & pte_u & (IS_ITLB | ~STATUS_SUM));
    // Fetches only need X; data reads may use X pages when MXR is set.
    assign access_fault = IS_ITLB ? ~pte_x
                        : ((ReadAccess & ~pte_r & ~(STATUS_MXR & pte_x))
                          | (WriteAccess & ~pte_w));
    assign need_da    = ~pte_a | (WriteAccess & ~pte_d);
    assign perm_fault = priv_fault | access_fault | ~pte_v | Misaligned
                      | upper_bits_unequal | (~HW_AD & need_da);

    // ---------------- lookup classification ----------------
    logic lookup, hit, adu_needed;
    assign lookup     = Translate & (ReadAccess | WriteAccess) & (state_q == S_IDLE);
    assign hit        = lookup & CAMHit;
    assign adu_needed = hit & ~perm_fault & need_da & HW_AD;

    assign TLBHit   = hit;
    assign TLBStall = (state_q != S_IDLE) | (lookup & ~CAMHit) | adu_needed;
    assign FlushIdx = flush_idx_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d      = state_q;
        flush_idx_d  = flush_idx_q;
        TLBPageFault = 1'b0;
        WalkReq      = 1'b0;
        WalkAbort    = 1'b0;
        TLBWrite     = 1'b0;
        DAReq        = 1'b0;
        FlushValid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hit & perm_fault)      TLBPageFault = 1'b1;
                else if (adu_needed)       state_d      = S_ADU;
                else if (lookup & ~CAMHit) state_d      = S_REQ;
            end
            S_REQ: begin
                WalkReq = 1'b1;
                // A walk that finishes in the accepting cycle completes directly.
                if (WalkAck) begin
                    if (WalkDone) state_d = WalkFault ? S_FAULT : S_FILL;
                    else          state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (WalkDone) state_d = WalkFault ? S_FAULT : S_FILL;
            end
            S_FILL: begin
                TLBWrite = 1'b1;
                state_d  = S_IDLE;
            end
            S_FAULT: begin
                TLBPageFault = 1'b1;
                state_d      = S_IDLE;
            end
            S_ADU: begin
                DAReq = 1'b1;
                if (DAAck) state_d = S_IDLE;
            end
            S_FLUSH: begin
                FlushValid = 1'b1;
                if (flush_idx_q == LAST_IDX) state_d = S_IDLE;
                else                         flush_idx_d = flush_idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush overrides every other transition and cancels outstanding work.
        if (TLBFlush) begin
            state_d     = S_FLUSH;
            flush_idx_d = '0;
            if (state_q == S_REQ || state_q == S_WAIT) begin
                WalkAbort = 1'b1;
                WalkReq   = 1'b0;
            end
            if (state_q == S_ADU) DAReq = 1'b0;
        end
    end

endmodule
